// File: rtl/arith_seq_defs.sv
// Shared definitions for the sequential arithmetic responder: FSM state
// encodings and the quotient value reported on a divide by zero.
package arith_seq_defs;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   // All-ones quotient for divide by zero; consumers slice the low W bits.
   // This covers operand widths up to 32 bits.
   localparam logic [31:0] DBZ_QUOT = 32'hFFFF_FFFF;

endpackage

// File: rtl/arith_div_step.sv
// One restoring-divide iteration: shift the next dividend bit into the
// partial remainder and subtract the divisor when it fits.
module arith_div_step #(
   parameter int W = 4
) (
   input  logic [W-1:0] rem_in,
   input  logic         dvd_bit,
   input  logic [W-1:0] divisor,
   output logic [W-1:0] rem_out,
   output logic         q_bit
);

   logic [W:0]   shifted;
   logic [W-1:0] sub;

   // Remainder after a successful subtract is below the divisor, so W-bit
   // modular subtraction of the low bits gives the exact result.
   always_comb begin
      shifted = {rem_in, dvd_bit};
      q_bit   = (shifted >= {1'b0, divisor});
      sub     = shifted[W-1:0] - divisor;
      rem_out = q_bit ? sub : shifted[W-1:0];
   end

endmodule

// File: rtl/arith_seq_responder.sv
// Sequential arithmetic responder: accepts an operand pair, returns sum and
// difference computed at accept plus a shift-add product and a restoring
// quotient/remainder that each take W iterations, one bit per clock.
module arith_seq_responder
   import arith_seq_defs::*;
#(
   parameter int W = 4
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [W-1:0]   a,
   input  logic [W-1:0]   b,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [W:0]     sum,
   output logic [W:0]     diff,
   output logic [2*W-1:0] prod,
   output logic [W-1:0]   quot,
   output logic [W-1:0]   rem,
   output logic           dbz
);

   localparam int             CW       = $clog2(W);
   localparam logic [W-1:0]   QUOT_DBZ = DBZ_QUOT[W-1:0];
   localparam logic [CW-1:0]  LAST     = CW'(W - 1);

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [W-1:0]     a_q, a_d, b_q, b_d;
   logic [2*W-1:0]   acc_q, acc_d, mc_q, mc_d;
   logic [W-1:0]     mp_q, mp_d, dvd_q, dvd_d, prem_q, prem_d, qw_q, qw_d;
   logic             in_ready_q, in_ready_d, out_valid_q, out_valid_d;
   logic [W:0]       sum_q, sum_d, diff_q, diff_d;
   logic [2*W-1:0]   prod_q, prod_d;
   logic [W-1:0]     quot_q, quot_d, rem_q, rem_d;
   logic             dbz_q, dbz_d;
   logic [W-1:0]     step_rem;
   logic             step_q;

   arith_div_step #(.W(W)) u_div_step (
      .rem_in  (prem_q),
      .dvd_bit (dvd_q[W-1]),
      .divisor (b_q),
      .rem_out (step_rem),
      .q_bit   (step_q)
   );

   // Next-state and datapath: accept in IDLE, iterate in CALC, hold in DONE.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      a_d         = a_q;
      b_d         = b_q;
      acc_d       = acc_q;
      mc_d        = mc_q;
      mp_d        = mp_q;
      dvd_d       = dvd_q;
      prem_d      = prem_q;
      qw_d        = qw_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;
      sum_d       = sum_q;
      diff_d      = diff_q;
      prod_d      = prod_q;
      quot_d      = quot_q;
      rem_d       = rem_q;
      dbz_d       = dbz_q;
      unique case (state_q)
         IDLE: begin
            in_ready_d = 1'b1;
            if (in_valid) begin
               a_d        = a;
               b_d        = b;
               sum_d      = {1'b0, a} + {1'b0, b};
               diff_d     = {1'b0, a} - {1'b0, b};
               acc_d      = '0;
               mc_d       = {{W{1'b0}}, a};
               mp_d       = b;
               dvd_d      = a;
               prem_d     = '0;
               qw_d       = '0;
               cnt_d      = '0;
               in_ready_d = 1'b0;
               state_d    = CALC;
            end
         end
         CALC: begin
            // Multiplicand shifts left while multiplier bits are consumed
            // from the LSB, equivalent to adding a<<count for each set bit.
            acc_d  = acc_q + (mp_q[0] ? mc_q : '0);
            mc_d   = mc_q << 1;
            mp_d   = mp_q >> 1;
            dvd_d  = dvd_q << 1;
            prem_d = step_rem;
            qw_d   = {qw_q[W-2:0], step_q};
            cnt_d  = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
               dbz_d       = (b_q == '0);
               prod_d      = dbz_d ? '0 : acc_d;
               quot_d      = dbz_d ? QUOT_DBZ : qw_d;
               rem_d       = dbz_d ? a_q : step_rem;
               out_valid_d = 1'b1;
               state_d     = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
               state_d     = IDLE;
            end
         end
         default: begin
            state_d    = IDLE;
            in_ready_d = 1'b1;
         end
      endcase
   end

   // State register; reset aborts any operation in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         a_q         <= '0;
         b_q         <= '0;
         acc_q       <= '0;
         mc_q        <= '0;
         mp_q        <= '0;
         dvd_q       <= '0;
         prem_q      <= '0;
         qw_q        <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         sum_q       <= '0;
         diff_q      <= '0;
         prod_q      <= '0;
         quot_q      <= '0;
         rem_q       <= '0;
         dbz_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         a_q         <= a_d;
         b_q         <= b_d;
         acc_q       <= acc_d;
         mc_q        <= mc_d;
         mp_q        <= mp_d;
         dvd_q       <= dvd_d;
         prem_q      <= prem_d;
         qw_q        <= qw_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         sum_q       <= sum_d;
         diff_q      <= diff_d;
         prod_q      <= prod_d;
         quot_q      <= quot_d;
         rem_q       <= rem_d;
         dbz_q       <= dbz_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign sum       = sum_q;
   assign diff      = diff_q;
   assign prod      = prod_q;
   assign quot      = quot_q;
   assign rem       = rem_q;
   assign dbz       = dbz_q;

endmodule

// File: tb/tb_arith_seq_responder.sv
// Scoreboard bench for arith_seq_responder (W=4): the driver pushes the
// hand-computed result for each accepted pair, the monitor pops and checks
// whenever out_valid is presented.
module tb_arith_seq_responder;
   localparam int W = 4;

   typedef struct {
      logic [4:0] sum;
      logic [4:0] diff;
      logic [7:0] prod;
      logic [3:0] quot;
      logic [3:0] rem;
      logic       dbz;
      int         acc;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [3:0] a = '0;
   logic [3:0] b = '0;
   logic       out_valid;
   logic       out_ready = 1'b1;
   logic [4:0] sum, diff;
   logic [7:0] prod;
   logic [3:0] quot, rem;
   logic       dbz;

   int   vectors = 0;
   int   miscompares = 0;
   int   cyc = 0;
   int   hs_cyc = -1;
   int   last_acc = -1;
   bit   have_cur = 0;
   exp_t cur;
   exp_t q[$];

   arith_seq_responder #(.W(W)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .diff(diff), .prod(prod), .quot(quot), .rem(rem), .dbz(dbz)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic exp_t mk(input int s, input int d, input int p,
                               input int qu, input int r, input int z);
      exp_t e;
      e.sum = 5'(s); e.diff = 5'(d); e.prod = 8'(p);
      e.quot = 4'(qu); e.rem = 4'(r); e.dbz = 1'(z); e.acc = 0;
      return e;
   endfunction

   // Offer a pair and hold in_valid until the DUT takes it.
   task automatic issue(input logic [3:0] ia, input logic [3:0] ib,
                        input exp_t e, input bit push);
      bit was_ready;
      int n = 0;
      a = ia; b = ib; in_valid = 1'b1;
      do begin
         was_ready = in_ready;
         @(posedge clk); #1;
         n++;
      end while (!was_ready && n < 40);
      in_valid = 1'b0;
      if (!was_ready) begin
         chk("accept_timeout", 0, 1);
         return;
      end
      last_acc = cyc;
      chk("in_ready_drop", int'(in_ready), 0);
      if (push) begin
         e.acc = cyc;
         q.push_back(e);
      end
   endtask

   task automatic drain();
      int n = 0;
      while ((q.size() != 0 || have_cur || out_valid) && n < 60) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 60) chk("drain_timeout", 0, 1);
   endtask

   task automatic chk_reset_outs(input string tag);
      chk({tag, "_in_ready"}, int'(in_ready), 1);
      chk({tag, "_out_valid"}, int'(out_valid), 0);
      chk({tag, "_outs"}, int'(sum) | int'(diff) | int'(prod) | int'(quot)
                          | int'(rem) | int'(dbz), 0);
   endtask

   // Monitor: pop on first valid cycle, compare every valid cycle so a
   // stalled result is also checked for stability.
   always @(negedge clk) begin
      if (!rst && out_valid) begin
         if (!have_cur) begin
            if (q.size() == 0) begin
               chk("unexpected_out_valid", 1, 0);
            end else begin
               cur = q.pop_front();
               have_cur = 1;
               chk("latency", cyc - cur.acc, W);
            end
         end
         if (have_cur) begin
            chk("sum", int'(sum), int'(cur.sum));
            chk("diff", int'(diff), int'(cur.diff));
            chk("prod", int'(prod), int'(cur.prod));
            chk("quot", int'(quot), int'(cur.quot));
            chk("rem", int'(rem), int'(cur.rem));
            chk("dbz", int'(dbz), int'(cur.dbz));
            if (out_ready) begin
               have_cur = 0;
               hs_cyc = cyc + 1;
            end
         end
      end
   end

   initial begin
      int n;
      repeat (2) @(posedge clk);
      #1;
      // Reset wins over a simultaneous in_valid.
      in_valid = 1'b1; a = 4'd1; b = 4'd1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      rst = 1'b0;
      chk_reset_outs("reset");

      issue(4'd3, 4'd8, mk(11, 27, 24, 0, 3, 0), 1);
      drain();
      issue(4'd11, 4'd7, mk(18, 4, 77, 1, 4, 0), 1);
      drain();
      chk("in_ready_after_hs", int'(in_ready), 1);
      issue(4'd9, 4'd0, mk(9, 9, 0, 15, 9, 1), 1);
      drain();

      // Stall the consumer for three cycles after out_valid.
      out_ready = 1'b0;
      issue(4'd15, 4'd15, mk(30, 0, 225, 1, 0, 0), 1);
      n = 0;
      while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
      if (!out_valid) chk("stall_wait_timeout", 0, 1);
      repeat (3) begin @(posedge clk); #1; end
      chk("stall_hold_valid", int'(out_valid), 1);
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("hs_first_edge", int'(out_valid), 0);
      chk("hs_in_ready", int'(in_ready), 1);

      // Reset during CALC aborts: nothing is expected from this pair.
      issue(4'd2, 4'd11, mk(0, 0, 0, 0, 0, 0), 0);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk_reset_outs("abort");
      repeat (W + 2) begin @(posedge clk); #1; end
      chk("abort_no_valid", int'(out_valid), 0);
      issue(4'd4, 4'd7, mk(11, 29, 28, 0, 4, 0), 1);
      drain();

      // Second pair offered while busy waits for the first IDLE edge.
      out_ready = 1'b0;
      issue(4'd6, 4'd3, mk(9, 3, 18, 2, 0, 0), 1);
      fork
         issue(4'd5, 4'd5, mk(10, 0, 25, 1, 0, 0), 1);
         begin
            repeat (W + 3) @(posedge clk);
            #1 out_ready = 1'b1;
         end
      join
      chk("busy_accept_edge", last_acc, hs_cyc + 1);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/arith_seq_responder.md
Name: arith_seq_responder

Overview:
- Sequential arithmetic responder: completes the operator stimulus flow by accepting an operand pair over a valid/ready handshake and returning a registered result bundle over a second handshake.
- Add and subtract are computed at the accept edge.
- Multiply (shift-add) and divide (restoring) iterate one bit per clock, in parallel.
- Sits as the device-under-request behind any operator stimulus driver or bench that issues operand pairs and collects results.

Parameters:
- W, 4, operand width in bits (W >= 2).

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operand pair offered
- in_ready  output  1  block can accept an operand pair
- a  input  W  operand A (unsigned)
- b  input  W  operand B (unsigned)
- out_valid  output  1  result bundle valid
- out_ready  input  1  consumer accepts result
- sum  output  W+1  a+b
- diff  output  W+1  a-b, two's complement modulo 2^(W+1)
- prod  output  2W  a*b
- quot  output  W  a/b
- rem  output  W  a%b
- dbz  output  1  divide-by-zero flag for this result

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset (synchronous, rst high at an edge), regardless of state:
  - state=IDLE, iteration counter=0.
  - in_ready=1, out_valid=0.
  - sum, diff, prod, quot, rem, dbz all 0.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1, accept: latch a and b, register sum and diff, load multiplier and divider working registers, count=0, go to CALC.
- CALC:
  - in_ready=0, out_valid=0.
  - Each edge performs one multiply step (add a<<count when bit count of b is set) and one restoring-divide step (shift in the next dividend MSB, subtract b if the partial remainder >= b, set the quotient bit), then count++.
  - The edge that completes step W-1 writes prod, quot, rem and dbz, sets out_valid=1 and goes to DONE.
- Latency: out_valid rises exactly W edges after the accepting edge (4 for W=4).
- DONE:
  - out_valid=1; outputs held stable while out_ready=0, for any duration.
  - Edge with out_ready=1: out_valid=0, go to IDLE.
  - in_ready stays 0 during DONE, so the earliest next accept is one edge after the result handshake.
  - Throughput: one operation per W+2 cycles.
- in_valid while in CALC or DONE is ignored; the bench must hold in_valid until in_ready.
- a and b are sampled only at the accept edge; later changes have no effect on the operation in flight.
- Divide by zero (b=0): quot = all ones (2^W-1), rem = a, dbz=1, prod=0. CALC still takes the full W cycles, so latency is uniform.
- dbz=0 for every b != 0.
- Width rules:
  - sum carries out into bit W.
  - diff wraps, e.g. W=4, 3-8 = 5'b11011 (27 unsigned).
  - prod is full 2W bits, no truncation.
- Reset asserted in CALC or DONE aborts the operation; no result is emitted and all outputs return to reset values on that edge.
- rst and in_valid high on the same edge: reset wins, nothing accepted.

Decomposition:
- Shared package/include (arith_seq_defs): state encodings IDLE=2'd0, CALC=2'd1, DONE=2'd2, and the divide-by-zero quotient constant.
- One natural sub-module, arith_div_step: combinational restoring-divide step. Inputs are partial remainder, dividend bit and divisor; outputs are the new remainder and the quotient bit. It is instantiated once inside the CALC datapath.
- Multiply step stays inline.

Test Plan:
- Reset then a=3, b=8, in_valid=1 one cycle -> in_ready drops next cycle; out_valid after exactly 4 edges; sum=11, diff=27, prod=24, quot=0, rem=3, dbz=0.
- a=11, b=7, out_ready=1 -> sum=18, diff=4, prod=77, quot=1, rem=4; in_ready returns 1 one edge after the result handshake.
- a=9, b=0 -> sum=9, diff=9, prod=0, quot=15, rem=9, dbz=1, same 4-edge latency.
- a=15, b=15 with out_ready=0 for 3 cycles after out_valid -> outputs stable (sum=30, diff=0, prod=225, quot=1, rem=0) for all 3 cycles; handshake completes on the first out_ready=1 edge.
- Accept a=2, b=11, assert rst for one edge during CALC (second edge) -> all outputs 0, in_ready=1, out_valid never pulses. A subsequent a=4, b=7 then yields sum=11, diff=29, prod=28, quot=0, rem=4.
- in_valid held high with a new pair (a=5, b=5) while busy -> not accepted until IDLE; the first result is unaffected, and the second pair is accepted at the first IDLE edge.
